// File: rtl/param_frame_rx.sv
// param_frame_rx
//   Pin-level frame receiver feeding the eigen core. Nibbles strobed on
//   asynchronous MCU pins are synchronised and assembled into two signed
//   32-bit coefficients, with an 8-bit additive checksum over the first
//   16 nibbles. Validated coefficients are handed to the core together with
//   a single-cycle start pulse, held off while the core reports busy.
//
// Ports
//   clk, rst_n  : system clock, asynchronous active-low reset
//   pin_data    : nibble data (async pins)
//   pin_stb     : nibble strobe, each toggle is one nibble event (async pin)
//   pin_sof     : start-of-frame marker taken with the nibble event (async pin)
//   core_busy   : core busy, start is withheld while high
//   a0, a1      : last successfully delivered coefficients
//   start_calc  : one-cycle start pulse, a0/a1 valid in the same cycle
//   frame_err   : sticky error for the last frame, cleared by the next sof
//   rx_busy     : frame being received or pending delivery
module param_frame_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  pin_data,
  input  logic        pin_stb,
  input  logic        pin_sof,
  input  logic        core_busy,
  output logic [31:0] a0,
  output logic [31:0] a1,
  output logic        start_calc,
  output logic        frame_err,
  output logic        rx_busy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RECV, CHK, WAIT_CORE, FIRE} state_t;

  state_t                   state, state_n;

  logic [SYNC_STAGES*4-1:0] data_sync;
  logic [SYNC_STAGES-1:0]   stb_sync;
  logic [SYNC_STAGES-1:0]   sof_sync;
  logic                     stb_prev;

  logic [3:0]               nib;
  logic                     sof;
  logic                     evt;

  logic [63:0]              shadow;
  logic [7:0]               rx_chk;
  logic [7:0]               sum;
  logic [4:0]               cnt;
  logic [TW-1:0]            tcnt;

  logic                     restart;
  logic                     take;
  logic                     err_set;
  logic                     load;

  assign nib = data_sync[SYNC_STAGES*4-1 -: 4];
  assign sof = sof_sync[SYNC_STAGES-1];
  assign evt = stb_sync[SYNC_STAGES-1] ^ stb_prev;

  // All three pin groups share the same depth so data/sof line up with the
  // strobe edge that announces them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sync <= '0;
      stb_sync  <= '0;
      sof_sync  <= '0;
      stb_prev  <= 1'b0;
    end else begin
      data_sync <= {data_sync[SYNC_STAGES*4-5:0], pin_data};
      stb_sync  <= {stb_sync[SYNC_STAGES-2:0], pin_stb};
      sof_sync  <= {sof_sync[SYNC_STAGES-2:0], pin_sof};
      stb_prev  <= stb_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // cnt holds the number of nibbles already captured, so cnt==17 marks the
  // final checksum nibble arriving.
  always_comb begin
    state_n = state;
    restart = 1'b0;
    take    = 1'b0;
    err_set = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (evt && sof) begin
          restart = 1'b1;
          state_n = RECV;
        end
      end
      RECV: begin
        if (evt) begin
          if (sof) begin
            restart = 1'b1;
          end else begin
            take = 1'b1;
            if (cnt == 5'd17) state_n = CHK;
          end
        end else if (tcnt == TW'(TIMEOUT)) begin
          err_set = 1'b1;
          state_n = IDLE;
        end
      end
      CHK: begin
        if (rx_chk != sum) begin
          err_set = 1'b1;
          state_n = IDLE;
        end else if (!core_busy) begin
          load    = 1'b1;
          state_n = FIRE;
        end else begin
          state_n = WAIT_CORE;
        end
      end
      WAIT_CORE: begin
        // A new sof abandons the pending frame silently.
        if (evt && sof) begin
          restart = 1'b1;
          state_n = RECV;
        end else if (!core_busy) begin
          load    = 1'b1;
          state_n = FIRE;
        end
      end
      FIRE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      rx_chk    <= '0;
      sum       <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      a0        <= '0;
      a1        <= '0;
      frame_err <= 1'b0;
    end else begin
      if (restart) begin
        shadow <= {shadow[59:0], nib};
        sum    <= {4'b0, nib};
        cnt    <= 5'd1;
      end else if (take) begin
        if (cnt < 5'd16) begin
          shadow <= {shadow[59:0], nib};
          sum    <= sum + {4'b0, nib};
        end else begin
          rx_chk <= {rx_chk[3:0], nib};
        end
        cnt <= cnt + 5'd1;
      end

      if (evt)                                   tcnt <= '0;
      else if (state == RECV && tcnt != TW'(TIMEOUT)) tcnt <= tcnt + 1'b1;

      // Loading on the way into FIRE makes a0/a1 valid alongside start_calc.
      if (load) begin
        a0 <= shadow[63:32];
        a1 <= shadow[31:0];
      end

      if (err_set)      frame_err <= 1'b1;
      else if (restart) frame_err <= 1'b0;
    end
  end

  assign start_calc = (state == FIRE);
  assign rx_busy    = (state != IDLE);

endmodule
